fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- IF-stage controller; the consumer end of the pipeline-stall interface.
- Owns the PC and drives the instruction-memory request/valid handshake.
- Fills the IF/ID register with instructions or NOP bubbles, obeying ST_if_id_en and ST_br_stall.
- On branch resolution from EX, holds fetch through the branch shadow and then redirects or falls through.

Parameters:
PC_W, 64, PC / address width
RESET_PC, 0, PC value loaded on reset
NOP_INST, 32'h47FF041F, bubble encoding written into IF/ID
BR_TIMEOUT, 8, max BR_WAIT cycles before forced exit (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ST_if_id_en  in  1  IF/ID register enable from stall unit
ST_br_stall  in  1  branch present in ID; suppress fetch
EX_br_valid  in  1  branch resolved this cycle
EX_br_taken  in  1  resolved taken (qualified by EX_br_valid)
EX_br_target  in  PC_W  taken target
Imem_req  out  1  fetch request
Imem_addr  out  PC_W  fetch address (=PC)
Imem_valid  in  1  Imem_data valid for Imem_addr
Imem_data  in  32  fetched instruction
IF_inst  out  32  IF/ID instruction (registered)
IF_npc  out  PC_W  IF/ID PC+4 of IF_inst (registered)
IF_valid  out  1  IF/ID holds a real instruction (registered)
FC_br_timeout  out  1  sticky: BR_WAIT timed out
FC_bubble_cnt  out  32  bubble counter (optional feature)

Behaviour:
- Clock and reset: clk only; rst synchronous, active-high.
- Reset values: PC=RESET_PC, state=FETCH, IF_inst=NOP_INST, IF_npc=0, IF_valid=0, FC_br_timeout=0, FC_bubble_cnt=0, wait counter=0.
- Reset mid-BR_WAIT: abandons the branch; the next cycle fetches from RESET_PC.

- State FETCH, fetch request:
  - Imem_req = !ST_br_stall.
  - Imem_addr = PC, held stable until accepted.
- FETCH accept condition: Imem_valid && ST_if_id_en && !ST_br_stall.
  - On accept: PC <= PC+4, IF_inst <= Imem_data, IF_npc <= PC+4, IF_valid <= 1. Single-cycle latency.
- FETCH with ST_if_id_en=1 but no accept: IF_inst <= NOP_INST, IF_valid <= 0 (bubble), PC held.
- FETCH with ST_if_id_en=0: IF_* hold; PC held; Imem_data dropped and re-requested.
- FETCH with ST_br_stall=1: no request; bubble written if ST_if_id_en; state <= BR_WAIT; counter <= 0.
- EX_br_valid in FETCH: ignored (no outstanding branch).

- State BR_WAIT:
  - Imem_req=0; bubbles written whenever ST_if_id_en; counter increments each cycle.
  - EX_br_valid=1: if EX_br_taken, PC <= EX_br_target, else PC unchanged (already branch PC+4). State <= FETCH; first fetch next cycle.
  - Timeout, counter == BR_TIMEOUT-1 with no EX_br_valid: FC_br_timeout <= 1, state <= FETCH, PC unchanged.
  - EX_br_valid and timeout in the same cycle: resolution wins; no timeout flag.
- Arithmetic: PC+4 wraps modulo 2^PC_W; EX_br_target low 2 bits are forced to 0.
- FC_br_timeout clears only on rst.

Optional Feature:
- Macro: FETCH_BUBBLE_CNT_EN.
- Defined: FC_bubble_cnt increments on every cycle where ST_if_id_en=1 and a bubble (IF_valid<=0) is written; saturates at 32'hFFFFFFFF.
- Undefined: no counter logic; FC_bubble_cnt tied to 0.

Decomposition:
- Add to sys_defs.vh: fetch state enum (FC_FETCH, FC_BR_WAIT) and `NOP_INST` constant; reuse `TRUE`/`FALSE`.
- One natural sub-module: fetch_pc_reg, holding the PC register with next-PC mux (reset / +4 / target / hold).

Test Plan:
- Reset, then Imem_valid=1 and ST_if_id_en=1 for 3 cycles -> Imem_addr 0,4,8; IF_npc 4,8,12; IF_valid=1.
- ST_if_id_en=0 for 2 cycles mid-stream -> IF_* and PC frozen; Imem_addr constant; resumes with no skipped address.
- ST_br_stall at PC=0x10, then EX_br_valid=1 taken to 0x80 two cycles later -> two bubbles (IF_inst=NOP_INST), next Imem_addr=0x80.
- Same branch resolved not-taken -> next Imem_addr=0x10; IF_npc=0x14 on accept.
- ST_br_stall with no EX_br_valid for 8 cycles -> FC_br_timeout=1 after cycle 8; fetch resumes at held PC; flag persists until rst.
- With FETCH_BUBBLE_CNT_EN, taken-branch scenario -> FC_bubble_cnt=3 (stall cycle + 2 wait); with rst asserted in BR_WAIT -> Imem_addr=RESET_PC next cycle, FC_bubble_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the IF-stage fetch controller
package fetch_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [31:0] FC_NOP_INST = 32'h47FF041F;

    typedef enum logic {
        FC_FETCH   = 1'b0,
        FC_BR_WAIT = 1'b1
    } fc_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with reset / +4 / target / hold selection
module fetch_pc_reg
    import fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4
);

    assign pc_plus4 = pc + PC_W'(4);

    // Branch targets are word aligned; the low two bits are discarded on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_INC:  pc <= pc_plus4;
                PC_LOAD: pc <= target & ~PC_W'(3);
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch controller; optional bubble counter under FETCH_BUBBLE_CNT_EN
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              PC_W       = 64,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [31:0]     NOP_INST   = FC_NOP_INST,
    parameter int              BR_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ST_if_id_en,
    input  logic            ST_br_stall,
    input  logic            EX_br_valid,
    input  logic            EX_br_taken,
    input  logic [PC_W-1:0] EX_br_target,
    output logic            Imem_req,
    output logic [PC_W-1:0] Imem_addr,
    input  logic            Imem_valid,
    input  logic [31:0]     Imem_data,
    output logic [31:0]     IF_inst,
    output logic [PC_W-1:0] IF_npc,
    output logic            IF_valid,
    output logic            FC_br_timeout,
    output logic [31:0]     FC_bubble_cnt
);

    localparam int              CNT_W    = $clog2(BR_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BR_TIMEOUT - 1);

    fc_state_t        state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [PC_W-1:0]  pc, pc_plus4;
    pc_sel_t          pc_sel;
    logic             accept, bubble, timeout_set;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .sel      (pc_sel),
        .target   (EX_br_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign Imem_addr = pc;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_sel       = PC_HOLD;
        Imem_req     = FALSE;
        accept       = FALSE;
        bubble       = FALSE;
        timeout_set  = FALSE;
        case (state)
            FC_FETCH: begin
                Imem_req = !ST_br_stall;
                accept   = Imem_valid && ST_if_id_en && !ST_br_stall;
                bubble   = ST_if_id_en && !accept;
                if (accept)
                    pc_sel = PC_INC;
                if (ST_br_stall) begin
                    state_nxt    = FC_BR_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            FC_BR_WAIT: begin
                bubble       = ST_if_id_en;
                wait_cnt_nxt = wait_cnt + CNT_W'(1);
                // A resolution arriving on the last wait cycle beats the timeout.
                if (EX_br_valid) begin
                    state_nxt = FC_FETCH;
                    if (EX_br_taken)
                        pc_sel = PC_LOAD;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt   = FC_FETCH;
                    timeout_set = TRUE;
                end
            end
            default: state_nxt = FC_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FC_FETCH;
            wait_cnt      <= '0;
            IF_inst       <= NOP_INST;
            IF_npc        <= '0;
            IF_valid      <= FALSE;
            FC_br_timeout <= FALSE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set)
                FC_br_timeout <= TRUE;
            if (accept) begin
                IF_inst  <= Imem_data;
                IF_npc   <= pc_plus4;
                IF_valid <= TRUE;
            end else if (bubble) begin
                IF_inst  <= NOP_INST;
                IF_valid <= FALSE;
            end
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 32'd1;
    end

    assign FC_bubble_cnt = bubble_cnt;
`else
    assign FC_bubble_cnt = '0;
`endif

endmodule
